// File: rtl/fetch_issue_queue.sv
// Elastic in-order buffer between fetch and issue: DEPTH-entry circular queue
// with valid/ready on both sides and a whole-queue flush for redirects.
module fetch_issue_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             in_pred,
  input  logic             in_branch,
  input  logic             in_jump,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_pred,
  output logic             out_branch,
  output logic             out_jump,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [XLEN-1:0]  instrMem_q [DEPTH];
  logic [XLEN-1:0]  pcMem_q    [DEPTH];
  logic             predMem_q  [DEPTH];
  logic             branchMem_q[DEPTH];
  logic             jumpMem_q  [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push;
  logic pop;
  logic writeEn;

  // Handshake qualifiers depend only on registered occupancy, so a pop while
  // full never frees a slot for a same-cycle push.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign writeEn   = push & ~flush & ~reset;
  assign count     = count_q;

  assign out_instr  = out_valid ? instrMem_q[head_q]  : '0;
  assign out_pc     = out_valid ? pcMem_q[head_q]     : '0;
  assign out_pred   = out_valid ? predMem_q[head_q]   : 1'b0;
  assign out_branch = out_valid ? branchMem_q[head_q] : 1'b0;
  assign out_jump   = out_valid ? jumpMem_q[head_q]   : 1'b0;

  // Flush discards the whole queue and ignores any same-cycle handshake.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (writeEn) begin
      instrMem_q[tail_q]  <= in_instr;
      pcMem_q[tail_q]     <= in_pc;
      predMem_q[tail_q]   <= in_pred;
      branchMem_q[tail_q] <= in_branch;
      jumpMem_q[tail_q]   <= in_jump;
    end
  end

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Self-checking bench for fetch_issue_queue: directed scenarios plus random
// traffic, all compared against a queue-based model of the buffer contents.
module tb_fetch_issue_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             in_pred;
  logic             in_branch;
  logic             in_jump;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_instr;
  logic [XLEN-1:0]  out_pc;
  logic             out_pred;
  logic             out_branch;
  logic             out_jump;
  logic [CNT_W-1:0] count;

  fetch_issue_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .in_pred(in_pred), .in_branch(in_branch), .in_jump(in_jump),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .out_pred(out_pred), .out_branch(out_branch), .out_jump(out_jump),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            pred;
    logic            branch;
    logic            jump;
  } packet_t;

  packet_t model[$];
  int vectors = 0;
  int miscompares = 0;
  logic [XLEN-1:0] nextPc;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle: check outputs against the model, clock, update model.
  task automatic applyStimulus(input logic v, input logic [XLEN-1:0] instr,
                               input logic [XLEN-1:0] pc, input logic pred,
                               input logic br, input logic jp,
                               input logic ordy, input logic fl, input logic rst);
    packet_t head;
    packet_t pkt;
    bit full, empty;
    in_valid  = v;   in_instr = instr; in_pc = pc;
    in_pred   = pred; in_branch = br;  in_jump = jp;
    out_ready = ordy; flush = fl;      reset = rst;
    #1;
    full  = (model.size() == DEPTH);
    empty = (model.size() == 0);
    head  = empty ? '0 : model[0];
    checkOutput("count",      64'(count),      64'(model.size()));
    checkOutput("in_ready",   64'(in_ready),   64'(!full));
    checkOutput("out_valid",  64'(out_valid),  64'(!empty));
    checkOutput("out_instr",  64'(out_instr),  64'(head.instr));
    checkOutput("out_pc",     64'(out_pc),     64'(head.pc));
    checkOutput("out_flags",  64'({out_pred, out_branch, out_jump}),
                64'({head.pred, head.branch, head.jump}));
    pkt = '{instr: instr, pc: pc, pred: pred, branch: br, jump: jp};
    @(posedge clk);
    if (rst || fl) model.delete();
    else begin
      if (!empty && ordy) void'(model.pop_front());
      if (v && !full) model.push_back(pkt);
    end
    #1;
  endtask

  task automatic pushPc(input logic [XLEN-1:0] pc, input logic ordy);
    applyStimulus(1'b1, ~pc, pc, 1'b0, 1'b0, 1'b0, ordy, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_pred = 1'b0; in_branch = 1'b0; in_jump = 1'b0;
    @(posedge clk); #1;

    // Reset then idle.
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    checkOutput("reset_pc_const", 64'(out_pc), 64'h0);

    // Fill to full, then drain in order.
    for (int i = 0; i < DEPTH; i++) pushPc(32'h100 + 32'(4 * i), 1'b0);
    checkOutput("full_count", 64'(count), 64'(DEPTH));
    checkOutput("full_ready", 64'(in_ready), 64'h0);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("drain_pc", 64'(out_pc), 64'(32'h100 + 32'(4 * i)));
      idle(1'b1);
    end
    idle(1'b0);

    // Hold two entries, then push and pop together across wraps.
    nextPc = 32'h400;
    pushPc(nextPc, 1'b0); nextPc += 4;
    pushPc(nextPc, 1'b0); nextPc += 4;
    for (int i = 0; i < 10; i++) begin
      pushPc(nextPc, 1'b1); nextPc += 4;
      checkOutput("steady_count", 64'(count), 64'h2);
    end
    idle(1'b1); idle(1'b1); idle(1'b0);

    // Flush with three held entries and a concurrent push/pop.
    for (int i = 0; i < 3; i++) pushPc(32'h500 + 32'(4 * i), 1'b0);
    applyStimulus(1'b1, 32'h0, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_count", 64'(count), 64'h0);
    pushPc(32'h300, 1'b0);
    checkOutput("post_flush_pc", 64'(out_pc), 64'h300);
    idle(1'b1);

    // Full with pop and push presented: push waits one cycle.
    for (int i = 0; i < DEPTH; i++) pushPc(32'h600 + 32'(4 * i), 1'b0);
    pushPc(32'h610, 1'b1);
    checkOutput("full_pop_count", 64'(count), 64'(DEPTH - 1));
    pushPc(32'h610, 1'b0);
    checkOutput("late_push_count", 64'(count), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) idle(1'b1);

    // Flag fields, then reset mid-stream.
    applyStimulus(1'b1, 32'hDEADBEEF, 32'h700, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("flag_instr", 64'(out_instr), 64'hDEADBEEF);
    checkOutput("flag_bits", 64'({out_pred, out_branch, out_jump}), 64'b110);
    pushPc(32'h704, 1'b0);
    applyStimulus(1'b1, 32'h1, 32'h708, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("reset_instr", 64'(out_instr), 64'h0);
    checkOutput("reset_valid", 64'(out_valid), 64'h0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 9) < 6), $urandom, $urandom,
                    1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom_range(0, 9) < 5),
                    1'($urandom_range(0, 31) == 0),
                    1'($urandom_range(0, 127) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
